// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded hold time per owner.
// Grant is registered as one-hot plus binary index; the previous owner always ranks last.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid
);

    localparam int CW = $clog2(MAX_HOLD) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    generate
        if (MAX_HOLD < 1 || MAX_HOLD > 256) begin : g_bad_cfg
            $fatal(1, "rr_arbiter8: MAX_HOLD=%0d outside legal range 1..256", MAX_HOLD);
        end
    endgenerate

    state_t          r_state;
    logic [2:0]      r_last_id;
    logic [CW-1:0]   r_hold_cnt;
    logic [7:0]      r_gnt;
    logic [2:0]      r_gnt_id;
    logic            r_valid;

    logic [2:0]      w_idx;
    logic [2:0]      w_win;
    logic            w_found;
    logic            w_any_req;
    logic            w_others;
    logic            w_owner_req;
    logic            w_timeout;

    // Search last_id+1 .. last_id+8; the +8 slot is the previous owner itself.
    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last_id;
        w_idx   = r_last_id;
        for (int i = 1; i <= 8; i++) begin
            w_idx = r_last_id + 3'(i);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_any_req   = |req;
    assign w_others    = |(req & ~r_gnt);
    assign w_owner_req = |(req & r_gnt);
    assign w_timeout   = (r_hold_cnt == CW'(MAX_HOLD - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_id  <= 3'd7;
            r_hold_cnt <= '0;
            r_gnt      <= 8'h00;
            r_gnt_id   <= 3'd0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state    <= BUSY;
                        r_gnt      <= 8'h01 << w_win;
                        r_gnt_id   <= w_win;
                        r_valid    <= 1'b1;
                        r_last_id  <= w_win;
                        r_hold_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (!w_owner_req) begin
                        r_hold_cnt <= '0;
                        if (w_any_req) begin
                            r_gnt     <= 8'h01 << w_win;
                            r_gnt_id  <= w_win;
                            r_last_id <= w_win;
                        end else begin
                            // gnt_id deliberately keeps the last owner while idle.
                            r_state <= IDLE;
                            r_gnt   <= 8'h00;
                            r_valid <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_hold_cnt <= '0;
                        if (w_others) begin
                            r_gnt     <= 8'h01 << w_win;
                            r_gnt_id  <= w_win;
                            r_last_id <= w_win;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 8'h00;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_valid;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: MAX_HOLD=4 main instance plus a MAX_HOLD=1 instance.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic [7:0] gnt1;
    logic [2:0] gnt_id1;
    logic       gnt_valid1;

    int checks;
    int errors;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid)
    );

    rr_arbiter8 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt1), .gnt_id(gnt_id1), .gnt_valid(gnt_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        req   = 8'hFF;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h want 00", gnt); end
        checks++;
        if (gnt_id !== 3'd0) begin errors++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
        checks++;
        if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt !== 8'h01) begin errors++; $display("FAIL reset_first_gnt: got %h want 01", gnt); end
        checks++;
        if (gnt_id !== 3'd0) begin errors++; $display("FAIL reset_first_id: got %0d want 0", gnt_id); end
        checks++;
        if (gnt_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %b want 1", gnt_valid); end
    endtask

    // Continues from test_reset: owner 0 holds gnt, all requesters active.
    task automatic test_rotation();
        logic [2:0] owner;
        logic [2:0] exp_id;
        owner = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            req = 8'hFF & ~(8'h01 << owner);
            step();
            exp_id = 3'(k);
            checks++;
            if (gnt !== (8'h01 << exp_id) || gnt_id !== exp_id || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL rotation_step%0d: got gnt=%h id=%0d valid=%b want gnt=%h id=%0d valid=1",
                         k, gnt, gnt_id, gnt_valid, 8'h01 << exp_id, exp_id);
            end
            owner = exp_id;
        end
    endtask

    task automatic test_timeout();
        logic [7:0] exp;
        logic [7:0] exp1;
        do_reset();
        req = 8'h09;
        for (int c = 0; c < 12; c++) begin
            step();
            exp  = ((c / 4) % 2 == 0) ? 8'h01 : 8'h08;
            exp1 = (c % 2 == 0) ? 8'h01 : 8'h08;
            checks++;
            if (gnt !== exp || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL timeout_cyc%0d: got gnt=%h valid=%b want gnt=%h valid=1", c, gnt, gnt_valid, exp);
            end
            checks++;
            if (gnt1 !== exp1) begin
                errors++;
                $display("FAIL hold1_cyc%0d: got gnt=%h want %h", c, gnt1, exp1);
            end
        end
    endtask

    task automatic test_sole();
        do_reset();
        req = 8'h20;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (gnt !== 8'h20 || gnt_id !== 3'd5 || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL sole_cyc%0d: got gnt=%h id=%0d valid=%b want gnt=20 id=5 valid=1",
                         c, gnt, gnt_id, gnt_valid);
            end
        end
    endtask

    task automatic test_idle_wrap();
        do_reset();
        req = 8'h40;
        step();
        checks++;
        if (gnt !== 8'h40) begin errors++; $display("FAIL wrap_own6: got %h want 40", gnt); end
        req = 8'h80;
        step();
        checks++;
        if (gnt !== 8'h80 || gnt_id !== 3'd7) begin
            errors++; $display("FAIL wrap_own7: got gnt=%h id=%0d want gnt=80 id=7", gnt, gnt_id);
        end
        req = 8'h00;
        step();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_idle: got gnt=%h valid=%b want gnt=00 valid=0", gnt, gnt_valid);
        end
        checks++;
        if (gnt_id !== 3'd7) begin errors++; $display("FAIL wrap_idle_id: got %0d want 7", gnt_id); end
        req = 8'h81;
        step();
        checks++;
        if (gnt !== 8'h01 || gnt_id !== 3'd0 || gnt_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_regrant: got gnt=%h id=%0d want gnt=01 id=0", gnt, gnt_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h10;
        step();
        checks++;
        if (gnt !== 8'h10) begin errors++; $display("FAIL async_pre: got %h want 10", gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL async_clear: got gnt=%h id=%0d valid=%b want gnt=00 id=0 valid=0",
                     gnt, gnt_id, gnt_valid);
        end
        req = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt !== 8'h01 || gnt_id !== 3'd0) begin
            errors++; $display("FAIL async_post: got gnt=%h id=%0d want gnt=01 id=0", gnt, gnt_id);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 8'h00;
        test_reset();
        test_rotation();
        test_timeout();
        test_sole();
        test_idle_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
